// File: rtl/maxpool_window.sv
// Streaming signed max-pool over windows of WIN elements (or shorter, closed by in_last).
// One pooled result per window through a single-entry registered valid/ready output.
module maxpool_window #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WIN    = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_len
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WIN - 1);

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] run_max_q, run_max_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic [CNT_W-1:0]         out_len_q, out_len_d;

  logic                     accept;
  logic                     close;
  logic signed [DATA_W-1:0] cand;

  // The output slot frees up in the same cycle it drains, so a new window can close behind it.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign close    = accept && ((cnt_q == LastIdx) || in_last);

  // First element seeds the window; ties keep the running max.
  always_comb begin
    cand = run_max_q;
    if (cnt_q == '0 || $signed(in_data) > run_max_q) begin
      cand = $signed(in_data);
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    run_max_d   = run_max_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_len_d   = out_len_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (close) begin
      out_data_d  = cand;
      out_len_d   = cnt_q + CNT_W'(1);
      out_valid_d = 1'b1;
      cnt_d       = '0;
    end else if (accept) begin
      run_max_d = cand;
      cnt_d     = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      run_max_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_len_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      run_max_q   <= run_max_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_len   = out_len_q;

endmodule
